// File: rtl/ac_actuator_driver_if.sv
// ============================================================================
// Module : ac_actuator_driver_if
// Brief  : Request/status bundle between the AC controller and actuator driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ac_actuator_driver_if;
    logic       ac_req;
    logic       fault;
    logic       fan_en;
    logic       comp_en;
    logic       ac_running;
    logic       busy;
    logic [2:0] state_o;

    modport master (
        output ac_req,
        output fault,
        input  fan_en,
        input  comp_en,
        input  ac_running,
        input  busy,
        input  state_o
    );

    modport slave (
        input  ac_req,
        input  fault,
        output fan_en,
        output comp_en,
        output ac_running,
        output busy,
        output state_o
    );
endinterface

`default_nettype wire

// File: rtl/ac_actuator_driver.sv
// ============================================================================
// Module : ac_actuator_driver
// Brief  : Sequences fan/compressor enables from a level AC request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ac_actuator_driver #(
    parameter int CNT_W       = 8,
    parameter int PRE_CYC     = 4,
    parameter int MIN_ON_CYC  = 8,
    parameter int POST_CYC    = 4,
    parameter int MIN_OFF_CYC = 16
) (
    input  wire                  clk,
    input  wire                  reset,
    ac_actuator_driver_if.slave  bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PRE  = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_POST = 3'd3;
    localparam logic [2:0] c_LOCK = 3'd4;

    localparam logic [CNT_W-1:0] c_PRE_LD  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] c_ON_LD   = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] c_POST_LD = CNT_W'(POST_CYC - 1);
    localparam logic [CNT_W-1:0] c_OFF_LD  = CNT_W'(MIN_OFF_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_dec_w;
    logic             cnt_zero_w;

    assign cnt_zero_w = (cnt_q == '0);
    // Saturating decrement: the timer rests at zero rather than wrapping.
    assign cnt_dec_w  = cnt_zero_w ? '0 : cnt_q - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_dec_w;
        case (state_q)
            c_IDLE: begin
                if (bus.ac_req && !bus.fault) begin
                    state_d = c_PRE;
                    cnt_d   = c_PRE_LD;
                end
            end
            c_PRE: begin
                if (bus.fault || !bus.ac_req) begin
                    state_d = c_POST;
                    cnt_d   = c_POST_LD;
                end else if (cnt_zero_w) begin
                    state_d = c_RUN;
                    cnt_d   = c_ON_LD;
                end
            end
            c_RUN: begin
                // Fault overrides the minimum on-time; a dropped request does not.
                if (bus.fault || (cnt_zero_w && !bus.ac_req)) begin
                    state_d = c_POST;
                    cnt_d   = c_POST_LD;
                end
            end
            c_POST: begin
                if (cnt_zero_w) begin
                    state_d = c_LOCK;
                    cnt_d   = c_OFF_LD;
                end
            end
            c_LOCK: begin
                if (cnt_zero_w) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.fan_en     = (state_q == c_PRE) || (state_q == c_RUN) || (state_q == c_POST);
        bus.comp_en    = (state_q == c_RUN);
        bus.ac_running = (state_q == c_RUN);
        bus.busy       = (state_q == c_PRE) || (state_q == c_RUN) ||
                         (state_q == c_POST) || (state_q == c_LOCK);
        bus.state_o    = state_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ac_actuator_driver.sv
// ============================================================================
// Module : tb_ac_actuator_driver
// Brief  : Directed and random stimulus against an elapsed-time phase model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ac_actuator_driver;

    localparam int PRE_CYC     = 4;
    localparam int MIN_ON_CYC  = 8;
    localparam int POST_CYC    = 4;
    localparam int MIN_OFF_CYC = 16;

    localparam int P_IDLE = 0;
    localparam int P_PRE  = 1;
    localparam int P_RUN  = 2;
    localparam int P_POST = 3;
    localparam int P_LOCK = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // Model: current phase and number of edges spent in it since entry.
    int   m_phase;
    int   m_age;
    int   comp_cycles;

    ac_actuator_driver_if bus ();

    ac_actuator_driver #(
        .CNT_W       (8),
        .PRE_CYC     (PRE_CYC),
        .MIN_ON_CYC  (MIN_ON_CYC),
        .POST_CYC    (POST_CYC),
        .MIN_OFF_CYC (MIN_OFF_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void enter(input int ph);
        m_phase = ph;
        m_age   = 0;
    endfunction

    function automatic void model_step(input logic req, input logic flt);
        case (m_phase)
            P_IDLE: if (req && !flt) enter(P_PRE);
            P_PRE: begin
                if (flt || !req)              enter(P_POST);
                else if (m_age >= PRE_CYC-1)  enter(P_RUN);
                else                          m_age++;
            end
            P_RUN: begin
                if (flt)                                enter(P_POST);
                else if (!req && m_age >= MIN_ON_CYC-1) enter(P_POST);
                else if (m_age < 100000)                m_age++;
            end
            P_POST: if (m_age >= POST_CYC-1)    enter(P_LOCK); else m_age++;
            default: if (m_age >= MIN_OFF_CYC-1) enter(P_IDLE); else m_age++;
        endcase
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, ".state"},   8'(bus.state_o),    8'(m_phase));
        check({tag, ".fan"},     8'(bus.fan_en),     8'(m_phase == P_PRE || m_phase == P_RUN || m_phase == P_POST));
        check({tag, ".comp"},    8'(bus.comp_en),    8'(m_phase == P_RUN));
        check({tag, ".running"}, 8'(bus.ac_running), 8'(m_phase == P_RUN));
        check({tag, ".busy"},    8'(bus.busy),       8'(m_phase != P_IDLE));
    endtask

    task automatic step(input logic req, input logic flt, input string tag);
        bus.ac_req = req;
        bus.fault  = flt;
        @(posedge clk);
        model_step(req, flt);
        #1;
        if (bus.comp_en === 1'b1) comp_cycles++;
        compare_outputs(tag);
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (m_phase != P_IDLE && guard < 200) begin
            step(1'b0, 1'b0, tag);
            guard++;
        end
        check({tag, ".idle_reached"}, 8'(m_phase == P_IDLE), 8'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        comp_cycles = 0;
        bus.ac_req = 1'b1;
        bus.fault  = 1'b0;
        reset      = 1'b1;
        enter(P_IDLE);
        #2;
        compare_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Normal cycle: request sampled high on edges 0..19.
        comp_cycles = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "normal");
        wait_idle("normal");
        check("normal.comp_cycles", 8'(comp_cycles), 8'd16);

        // Short request, dropped before compressor start.
        comp_cycles = 0;
        step(1'b1, 1'b0, "short");
        step(1'b1, 1'b0, "short");
        wait_idle("short");
        check("short.comp_cycles", 8'(comp_cycles), 8'd0);

        // Minimum on-time: request drops two edges into RUN.
        comp_cycles = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "minon");
        wait_idle("minon");
        check("minon.comp_cycles", 8'(comp_cycles), 8'(MIN_ON_CYC));

        // Fault in RUN at edge 6, request held high through the lockout.
        comp_cycles = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "fault");
        step(1'b1, 1'b1, "fault");
        check("fault.comp_off", 8'(bus.comp_en), 8'd0);
        for (int i = 7; i <= 27; i++) step(1'b1, 1'b0, "relock");
        check("relock.pre_at_27", 8'(bus.state_o), 8'd1);
        check("relock.comp_cycles", 8'(comp_cycles), 8'd2);

        // Async reset mid-RUN, applied between clock edges.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "prerst");
        #2;
        reset = 1'b1;
        enter(P_IDLE);
        #1;
        compare_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, "post_rst");
        check("post_rst.pre", 8'(bus.state_o), 8'd1);

        // Random request/fault patterns.
        begin
            logic req;
            logic flt;
            req = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 11) == 0) req = ~req;
                flt = ($urandom_range(0, 30) == 0);
                step(req, flt, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
